// File: rtl/mul_pkg.sv
// Shared types for the multiplier operand issue path: the operand pair
// carried through the queue and the issue FSM state encoding.
package mul_pkg;

   localparam int MUL_DATA_WIDTH = 32;

   typedef struct packed {
      logic [MUL_DATA_WIDTH-1:0] a;
      logic [MUL_DATA_WIDTH-1:0] b;
   } operand_pair_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } issue_state_t;

endpackage

// File: rtl/mul_issue_queue_sync_fifo.sv
// Synchronous FIFO with element-type parameter; head entry is presented
// combinationally on rdata. DEPTH must be a power of two.
module sync_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clk_en,
   input  logic                     push,
   input  logic                     pop,
   input  T                         wdata,
   output T                         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;
   T              mem_r [DEPTH];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= (PW+1)'(0);
      end else if (clk_en) begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset since count_r gates visibility.
   always_ff @(posedge clk) begin
      if (clk_en && push) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = (count_r == (PW+1)'(DEPTH));
   assign empty = (count_r == (PW+1)'(0));

endmodule

// File: rtl/mul_issue_queue.sv
// Operand issue buffer feeding a multi-cycle multiplier, one operation in flight.
// Optional MUL_ISSUE_BYPASS_EN: an idle, empty queue forwards a pushed pair directly.
module mul_issue_queue
   import mul_pkg::*;
#(
   parameter int DATA_WIDTH = MUL_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       clk_en_i,
   input  logic [DATA_WIDTH-1:0]      operand_A_i,
   input  logic [DATA_WIDTH-1:0]      operand_B_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic                       mul_busy_i,
   input  logic                       mul_data_valid_i,
   output logic [DATA_WIDTH-1:0]      mul_operand_A_o,
   output logic [DATA_WIDTH-1:0]      mul_operand_B_o,
   output logic                       mul_valid_entry_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o,
   output logic                       full_o
);

   issue_state_t  state_r;
   issue_state_t  next_state_s;
   operand_pair_t in_pair_s;
   operand_pair_t head_s;
   operand_pair_t issue_pair_s;
   operand_pair_t operands_r;
   logic          valid_entry_r;
   logic          push_req_s;
   logic          fifo_push_s;
   logic          fifo_pop_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          issue_s;
   logic          bypass_s;

   assign in_pair_s   = {operand_A_i, operand_B_i};
   assign ready_o     = !fifo_full_s & clk_en_i;
   assign push_req_s  = valid_i & ready_o;
   assign fifo_push_s = push_req_s & !bypass_s;

   sync_fifo #(
      .DEPTH (DEPTH),
      .T     (operand_pair_t)
   ) u_fifo (
      .clk    (clk_i),
      .rst_n  (rst_n_i),
      .clk_en (clk_en_i),
      .push   (fifo_push_s),
      .pop    (fifo_pop_s),
      .wdata  (in_pair_s),
      .rdata  (head_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s),
      .count  (count_o)
   );

   // Issue decision: IDLE issues when work is available and the multiplier is free.
   always_comb begin
      next_state_s = state_r;
      issue_s      = 1'b0;
      fifo_pop_s   = 1'b0;
      bypass_s     = 1'b0;
      issue_pair_s = head_s;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s && !mul_busy_i) begin
               issue_s      = 1'b1;
               fifo_pop_s   = 1'b1;
               next_state_s = WAIT;
            end
`ifdef MUL_ISSUE_BYPASS_EN
            else if (push_req_s && !mul_busy_i) begin
               issue_s      = 1'b1;
               bypass_s     = 1'b1;
               issue_pair_s = in_pair_s;
               next_state_s = WAIT;
            end
`endif
            else begin
               next_state_s = IDLE;
            end
         end
         WAIT: begin
            // Re-issue is deferred to the edge after the result is sampled.
            if (mul_data_valid_i) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = WAIT;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Registered FSM state and multiplier-facing outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r       <= IDLE;
         operands_r    <= '{a: {DATA_WIDTH{1'b0}}, b: {DATA_WIDTH{1'b0}}};
         valid_entry_r <= 1'b0;
      end else if (clk_en_i) begin
         state_r       <= next_state_s;
         valid_entry_r <= issue_s;
         if (issue_s) begin
            operands_r <= issue_pair_s;
         end
      end
   end

   assign mul_operand_A_o   = operands_r.a;
   assign mul_operand_B_o   = operands_r.b;
   assign mul_valid_entry_o = valid_entry_r;
   assign empty_o           = fifo_empty_s;
   assign full_o            = fifo_full_s;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Randomised bench for mul_issue_queue: a queue-based reference model plus a
// behavioural multiplier that answers each issue after a random latency.
module tb_mul_issue_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clk_en;
   logic          valid;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          ready;
   logic          busy;
   logic          dv;
   logic [DW-1:0] mul_a;
   logic [DW-1:0] mul_b;
   logic          ve;
   logic [2:0]    count;
   logic          empty;
   logic          full;

   mul_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .clk_en_i          (clk_en),
      .operand_A_i       (a),
      .operand_B_i       (b),
      .valid_i           (valid),
      .ready_o           (ready),
      .mul_busy_i        (busy),
      .mul_data_valid_i  (dv),
      .mul_operand_A_o   (mul_a),
      .mul_operand_B_o   (mul_b),
      .mul_valid_entry_o (ve),
      .count_o           (count),
      .empty_o           (empty),
      .full_o            (full)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [63:0] q[$];
   bit          in_flight  = 1'b0;
   logic [63:0] last_pair  = 64'd0;
   bit          exp_ve     = 1'b0;
   bit          last_push  = 1'b0;
   // Behavioural multiplier state
   bit          mul_active = 1'b0;
   int          mul_cnt    = 0;
   int          lat_max    = 4;
   bit          force_busy = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit v, input logic [31:0] ia, input logic [31:0] ib, input bit ce);
      bit issue;
      bit byp;
      bit push;
      @(negedge clk);
      valid  = v;
      a      = ia;
      b      = ib;
      clk_en = ce;
      if (ce) begin
         if (mul_active) begin
            if (mul_cnt == 0) begin
               busy = 1'b0; dv = 1'b1; mul_active = 1'b0;
            end else begin
               busy = 1'b1; dv = 1'b0; mul_cnt--;
            end
         end else begin
            busy = force_busy;
            dv   = ($urandom_range(0, 7) == 0);
         end
      end
      #1;
      check("ready", ready, (q.size() < DEPTH) && ce);
      push  = v && ce && (q.size() < DEPTH);
      issue = 1'b0;
      byp   = 1'b0;
      if (ce && !in_flight && !busy) begin
         if (q.size() > 0) begin
            issue = 1'b1;
            last_pair = q.pop_front();
         end
`ifdef MUL_ISSUE_BYPASS_EN
         else if (push) begin
            issue = 1'b1;
            byp   = 1'b1;
            last_pair = {ia, ib};
         end
`endif
      end
      if (push && !byp) q.push_back({ia, ib});
      last_push = push;
      if (ce) begin
         if (issue) in_flight = 1'b1;
         else if (in_flight && dv) in_flight = 1'b0;
         exp_ve = issue;
      end
      if (issue) begin
         mul_active = 1'b1;
         mul_cnt    = $urandom_range(0, lat_max);
      end
      @(posedge clk);
      #1;
      check("valid_entry", ve, exp_ve);
      check("op_a", mul_a, last_pair[63:32]);
      check("op_b", mul_b, last_pair[31:0]);
      check("count", count, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() > 0 || in_flight || mul_active) && n < 300) begin
         cycle(1'b0, 32'd0, 32'd0, 1'b1);
         n++;
      end
      if (q.size() > 0 || in_flight) check("drain_timeout", 64'd1, 64'd0);
   endtask

   task automatic check_reset_values();
      check("rst_ve", ve, 64'd0);
      check("rst_op_a", mul_a, 64'd0);
      check("rst_op_b", mul_b, 64'd0);
      check("rst_count", count, 64'd0);
      check("rst_empty", empty, 64'd1);
      check("rst_full", full, 64'd0);
      check("rst_ready", ready, 64'd1);
   endtask

   task automatic model_reset();
      q.delete();
      in_flight  = 1'b0;
      mul_active = 1'b0;
      last_pair  = 64'd0;
      exp_ve     = 1'b0;
      busy       = 1'b0;
      dv         = 1'b0;
   endtask

   initial begin
      logic signed [63:0] prod;
      int pushed;
      int guard;
      rst_n = 1'b0; clk_en = 1'b1; valid = 1'b0; a = 32'd0; b = 32'd0;
      busy = 1'b0; dv = 1'b0;
      #12;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1);

      // Single push: 7 * -3
      cycle(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
      prod = $signed(mul_a) * $signed(mul_b);
      check("product", prod, 64'hFFFF_FFFF_FFFF_FFEB);
      drain();

      // Burst of five with the multiplier held busy
      force_busy = 1'b1;
      for (int i = 1; i <= 4; i++) cycle(1'b1, i, 32'd10, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'd5, 32'd10, 1'b1);
      force_busy = 1'b0;
      guard = 0;
      do begin
         cycle(1'b1, 32'd5, 32'd10, 1'b1);
         guard++;
      end while (!last_push && guard < 100);
      if (!last_push) check("burst_timeout", 64'd1, 64'd0);
      drain();

      // Simultaneous push and pop at count 2
      force_busy = 1'b1;
      cycle(1'b1, 32'd21, 32'd3, 1'b1);
      cycle(1'b1, 32'd22, 32'd3, 1'b1);
      force_busy = 1'b0;
      cycle(1'b1, 32'd23, 32'd3, 1'b1);
      drain();

      // Randomised traffic: 1000 accepted pairs
      pushed = 0;
      guard  = 0;
      while (pushed < 1000 && guard < 20000) begin
         force_busy = ($urandom_range(0, 15) == 0);
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 9) != 0);
         if (last_push) pushed++;
         guard++;
      end
      if (pushed < 1000) check("random_timeout", 64'd1, 64'd0);
      force_busy = 1'b0;
      drain();

      // Asynchronous reset while WAITing with three entries queued
      lat_max = 30;
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + i, 32'h200 + i, 1'b1);
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(negedge clk);
      rst_n   = 1'b1;
      lat_max = 4;
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1);

      // Clock enable low during WAIT, including right after the issue edge
      lat_max = 8;
      cycle(1'b1, 32'hDEAD_0001, 32'h0000_0003, 1'b1);
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h55, 32'h66, 1'b0);
      cycle(1'b1, 32'h77, 32'h88, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0);
      lat_max = 4;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
